calc_sequencer: RTL

//  Expression sequencer for the calculator datapath. On a debounced cal pulse it pops tokens from the

---
 rtl/calc_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
// Purpose: pops "n1 op n2 =" tokens from the show-ahead FIFO, evaluates + - * and presents a sign/magnitude result.
// Latency: done at edge T+2 for add/sub and T+1+OPW for multiply (start edge = 1, T = tokens popped).
// Backpressure: one pop per cycle, only while the FIFO is non-empty; start is ignored unless idle.
module calc_sequencer #(
  parameter int OPW        = 7,
  parameter int MAX_DIGITS = 2,
  parameter int RES_W      = 14
) (
  input  logic             CLK_50M,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             res_sign,
  output logic [RES_W-1:0] res_mag
);

  localparam int CNT_MAX = (OPW > MAX_DIGITS) ? OPW : MAX_DIGITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_N1, S_N2, S_CALC, S_FIN, S_ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [OPW-1:0]   acc_a_q, acc_a_d;
  logic [OPW-1:0]   acc_b_q, acc_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] mcand_q, mcand_d;
  logic [RES_W-1:0] mag_q, mag_d;
  logic             sign_q, sign_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             is_digit, is_op, is_eq;
  logic [OPW-1:0]   digit_val;
  op_t              tok_op;

  // Token classification of the current FIFO head.
  always_comb begin
    is_digit  = (fifo_data <= 4'd9);
    is_op     = (fifo_data == 4'hA) || (fifo_data == 4'hB) || (fifo_data == 4'hC);
    is_eq     = (fifo_data == 4'hD);
    digit_val = OPW'(fifo_data);
    if (fifo_data == 4'hA)      tok_op = OP_ADD;
    else if (fifo_data == 4'hB) tok_op = OP_SUB;
    else                        tok_op = OP_MUL;
  end

  // Parser / evaluator next-state logic; the pop strobe is decided here so it lands in the same cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    err_d   = err_q;
    done_d  = 1'b0;
    fifo_rd = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_N1;
          acc_a_d = '0;
          acc_b_d = '0;
          cnt_d   = '0;
          mcand_d = '0;
          mag_d   = '0;
          sign_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_N1: begin
        if (fifo_empty) begin
          state_d = S_ERR;
        end else if (is_digit && (cnt_q < CNT_W'(MAX_DIGITS))) begin
          fifo_rd = 1'b1;
          acc_a_d = OPW'(acc_a_q * OPW'(10)) + digit_val;
          cnt_d   = cnt_q + 1'b1;
        end else if (is_op && (cnt_q != '0)) begin
          fifo_rd = 1'b1;
          op_d    = tok_op;
          cnt_d   = '0;
          state_d = S_N2;
        end else begin
          state_d = S_ERR;
        end
      end
      S_N2: begin
        if (fifo_empty) begin
          state_d = S_ERR;
        end else if (is_digit && (cnt_q < CNT_W'(MAX_DIGITS))) begin
          fifo_rd = 1'b1;
          acc_b_d = OPW'(acc_b_q * OPW'(10)) + digit_val;
          cnt_d   = cnt_q + 1'b1;
        end else if (is_eq && (cnt_q != '0)) begin
          fifo_rd = 1'b1;
          cnt_d   = '0;
          mcand_d = RES_W'(acc_a_q);
          state_d = S_CALC;
        end else begin
          state_d = S_ERR;
        end
      end
      S_CALC: begin
        case (op_q)
          OP_ADD: begin
            mag_d   = RES_W'(acc_a_q) + RES_W'(acc_b_q);
            state_d = S_FIN;
            done_d  = 1'b1;
          end
          OP_SUB: begin
            sign_d  = (acc_a_q < acc_b_q);
            mag_d   = (acc_a_q >= acc_b_q) ? RES_W'(acc_a_q - acc_b_q) : RES_W'(acc_b_q - acc_a_q);
            state_d = S_FIN;
            done_d  = 1'b1;
          end
          default: begin
            // Shift-add: consume one multiplier bit (LSB first) per cycle for exactly OPW cycles.
            sign_d  = 1'b0;
            if (acc_b_q[0]) mag_d = mag_q + mcand_q;
            mcand_d = mcand_q << 1;
            acc_b_d = acc_b_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(OPW - 1)) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end
          end
        endcase
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        // Drain whatever is left of the bad expression, then report.
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
        end else begin
          err_d   = 1'b1;
          sign_d  = 1'b0;
          mag_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset abandons any expression in flight.
  always_ff @(posedge CLK_50M or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      acc_a_q <= '0;
      acc_b_q <= '0;
      cnt_q   <= '0;
      mcand_q <= '0;
      mag_q   <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mag_q   <= mag_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign res_sign = sign_q;
  assign res_mag  = mag_q;

endmodule
